// File: rtl/stopwatch_bcd_if.sv
// Button/tick inputs and BCD display outputs of the MM:SS.CC stopwatch.
interface stopwatch_bcd_if;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] cs_lo;
    logic [3:0] cs_hi;
    logic [3:0] s_lo;
    logic [3:0] s_hi;
    logic [3:0] m_lo;
    logic [3:0] m_hi;
    logic       running;
    logic       lap_hold;
    logic       wrap;

    modport master (
        output tick, start_stop, clear, lap,
        input  cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi, running, lap_hold, wrap
    );

    modport slave (
        input  tick, start_stop, clear, lap,
        output cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi, running, lap_hold, wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch MM:SS.CC counting 100 Hz ticks under start/stop, clear and lap-freeze control.
module stopwatch_bcd #(
    parameter int MAX_MIN_HI = 5
) (
    input logic            clk,
    input logic            rst,
    stopwatch_bcd_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [23:0] MAX_CNT = {4'(MAX_MIN_HI), 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t      state, state_n;
    logic        armed, ss_q, clr_q, lap_q;
    logic        ss_rise, clr_rise, lap_rise;
    logic        hold, hold_n;
    logic        count_en, wrap_q;
    logic [23:0] live, live_n, snap, snap_n, disp, disp_n;

    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            3:       return 4'd5;
            5:       return 4'(MAX_MIN_HI);
            default: return 4'd9;
        endcase
    endfunction

    // Ripple carry: a digit advances only when every lower digit is at its max.
    function automatic logic [23:0] bcd_inc(input logic [23:0] d);
        logic [23:0] r;
        logic        carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] == digit_max(i)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // armed masks the first cycle after reset so a button held through release never fires.
    assign ss_rise  = armed & sw.start_stop & ~ss_q;
    assign clr_rise = armed & sw.clear      & ~clr_q;
    assign lap_rise = armed & sw.lap        & ~lap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
            lap_q <= 1'b0;
        end else begin
            armed <= 1'b1;
            ss_q  <= sw.start_stop;
            clr_q <= sw.clear;
            lap_q <= sw.lap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hold   <= 1'b0;
            live   <= '0;
            snap   <= '0;
            disp   <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_n;
            hold   <= hold_n;
            live   <= live_n;
            snap   <= snap_n;
            disp   <= disp_n;
            wrap_q <= count_en && (live == MAX_CNT);
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        if (clr_rise) begin
            state_n = IDLE;
            hold_n  = 1'b0;
        end else if (ss_rise) begin
            case (state)
                IDLE:    state_n = RUN;
                RUN:     state_n = STOP;
                STOP:    state_n = RUN;
                default: state_n = IDLE;
            endcase
        end else if (lap_rise) begin
            if (state == RUN)       hold_n = ~hold;
            else if (state == STOP) hold_n = 1'b0;
        end
    end

    // A tick counts whenever the cycle starts in RUN, even if this cycle's press stops the watch.
    assign count_en = sw.tick && (state == RUN) && !clr_rise;

    always_comb begin
        live_n = live;
        if (clr_rise)      live_n = '0;
        else if (count_en) live_n = bcd_inc(live);
        snap_n = (hold_n && !hold) ? live_n : snap;
        disp_n = hold_n ? snap_n : live_n;
    end

    assign {sw.m_hi, sw.m_lo, sw.s_hi, sw.s_lo, sw.cs_hi, sw.cs_lo} = disp;
    assign sw.running  = (state == RUN);
    assign sw.lap_hold = hold;
    assign sw.wrap     = wrap_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: default instance plus a MAX_MIN_HI=0 instance for wrap.
module tb_stopwatch_bcd;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    stopwatch_bcd_if sw ();
    stopwatch_bcd_if sw2 ();

    stopwatch_bcd #(.MAX_MIN_HI(5)) dut  (.clk(clk), .rst(rst), .sw(sw.slave));
    stopwatch_bcd #(.MAX_MIN_HI(0)) dut2 (.clk(clk), .rst(rst), .sw(sw2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] disp1();
        return {8'h00, sw.m_hi, sw.m_lo, sw.s_hi, sw.s_lo, sw.cs_hi, sw.cs_lo};
    endfunction

    function automatic logic [31:0] disp2();
        return {8'h00, sw2.m_hi, sw2.m_lo, sw2.s_hi, sw2.s_lo, sw2.cs_hi, sw2.cs_lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        sw.tick = 1'b1;
        step(n);
        sw.tick = 1'b0;
    endtask

    task automatic press_ss();
        sw.start_stop = 1'b1; step(1); sw.start_stop = 1'b0; step(1);
    endtask

    task automatic press_clear();
        sw.clear = 1'b1; step(1); sw.clear = 1'b0; step(1);
    endtask

    task automatic press_lap();
        sw.lap = 1'b1; step(1); sw.lap = 1'b0; step(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sw.tick  = 1'b0; sw.start_stop  = 1'b1; sw.clear  = 1'b0; sw.lap  = 1'b0;
        sw2.tick = 1'b0; sw2.start_stop = 1'b0; sw2.clear = 1'b0; sw2.lap = 1'b0;
        rst = 1'b1;
        step(3);
        check("rst_disp", disp1(), 32'h000000);
        check("rst_running", {31'd0, sw.running}, 32'd0);
        check("rst_lap_hold", {31'd0, sw.lap_hold}, 32'd0);
        check("rst_wrap", {31'd0, sw.wrap}, 32'd0);

        // start_stop held high through reset release must not start the watch
        rst = 1'b0;
        step(3);
        check("held_btn_running", {31'd0, sw.running}, 32'd0);
        ticks(2);
        step(1);
        check("held_btn_disp", disp1(), 32'h000000);
        sw.start_stop = 1'b0;
        step(1);

        // basic count: 100 ticks spaced 20 clocks
        press_ss();
        check("start_running", {31'd0, sw.running}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            sw.tick = 1'b1; step(1); sw.tick = 1'b0; step(19);
        end
        check("basic_disp", disp1(), 32'h000100);
        press_ss();
        check("stop_running", {31'd0, sw.running}, 32'd0);
        ticks(5);
        step(1);
        check("stopped_hold", disp1(), 32'h000100);

        press_clear();
        check("clear_disp", disp1(), 32'h000000);

        // carry chain seconds -> minutes
        press_ss();
        ticks(5999);
        check("to_005999", disp1(), 32'h005999);
        ticks(1);
        check("carry_010000", disp1(), 32'h010000);

        // lap freeze
        press_clear();
        press_ss();
        ticks(500);
        check("pre_lap", disp1(), 32'h000500);
        press_lap();
        check("lap_set", {31'd0, sw.lap_hold}, 32'd1);
        ticks(100);
        check("lap_frozen_mid", disp1(), 32'h000500);
        ticks(150);
        check("lap_frozen_end", disp1(), 32'h000500);
        press_lap();
        check("lap_release_hold", {31'd0, sw.lap_hold}, 32'd0);
        check("lap_release_disp", disp1(), 32'h000750);

        // lap in STOP only clears the freeze
        press_lap();
        check("lap_run_set", {31'd0, sw.lap_hold}, 32'd1);
        press_ss();
        check("lap_stop_running", {31'd0, sw.running}, 32'd0);
        press_lap();
        check("lap_stop_clear", {31'd0, sw.lap_hold}, 32'd0);
        press_lap();
        check("lap_stop_no_set", {31'd0, sw.lap_hold}, 32'd0);
        check("lap_stop_disp", disp1(), 32'h000750);

        // clear + start_stop + tick together in RUN
        press_clear();
        press_ss();
        ticks(321);
        check("pre_simul", disp1(), 32'h000321);
        sw.clear = 1'b1; sw.start_stop = 1'b1; sw.tick = 1'b1;
        step(1);
        sw.clear = 1'b0; sw.start_stop = 1'b0; sw.tick = 1'b0;
        check("simul_clear_disp", disp1(), 32'h000000);
        check("simul_clear_running", {31'd0, sw.running}, 32'd0);
        ticks(3);
        check("idle_no_count", disp1(), 32'h000000);

        // stop with coincident tick counts it; restart with coincident tick does not
        press_ss();
        ticks(9);
        check("pre_stop_tick", disp1(), 32'h000009);
        sw.start_stop = 1'b1; sw.tick = 1'b1;
        step(1);
        sw.start_stop = 1'b0; sw.tick = 1'b0;
        check("stop_tick_running", {31'd0, sw.running}, 32'd0);
        check("stop_tick_disp", disp1(), 32'h000010);
        step(1);
        sw.start_stop = 1'b1; sw.tick = 1'b1;
        step(1);
        sw.start_stop = 1'b0; sw.tick = 1'b0;
        check("restart_tick_running", {31'd0, sw.running}, 32'd1);
        check("restart_tick_disp", disp1(), 32'h000010);

        // asynchronous reset mid-run at 00:12.34 with lap frozen
        press_clear();
        press_ss();
        ticks(1234);
        check("pre_rst", disp1(), 32'h001234);
        press_lap();
        check("pre_rst_lap", {31'd0, sw.lap_hold}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_disp", disp1(), 32'h000000);
        check("async_rst_running", {31'd0, sw.running}, 32'd0);
        check("async_rst_lap", {31'd0, sw.lap_hold}, 32'd0);
        check("async_rst_wrap", {31'd0, sw.wrap}, 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        ticks(4);
        check("post_rst_no_count", disp1(), 32'h000000);

        // long run: default instance carries to 10:00.00, MAX_MIN_HI=0 instance wraps
        sw.start_stop = 1'b1; sw2.start_stop = 1'b1;
        step(1);
        sw.start_stop = 1'b0; sw2.start_stop = 1'b0;
        step(1);
        sw.tick = 1'b1; sw2.tick = 1'b1;
        step(59999);
        check("long_095999", disp1(), 32'h095999);
        check("long2_095999", disp2(), 32'h095999);
        check("long2_no_wrap", {31'd0, sw2.wrap}, 32'd0);
        step(1);
        sw.tick = 1'b0; sw2.tick = 1'b0;
        check("carry_100000", disp1(), 32'h100000);
        check("wrap_disp", disp2(), 32'h000000);
        check("wrap_pulse", {31'd0, sw2.wrap}, 32'd1);
        check("wrap_running", {31'd0, sw2.running}, 32'd1);
        check("no_wrap_default", {31'd0, sw.wrap}, 32'd0);
        step(1);
        check("wrap_one_cycle", {31'd0, sw2.wrap}, 32'd0);
        sw2.tick = 1'b1;
        step(1);
        sw2.tick = 1'b0;
        check("after_wrap_count", disp2(), 32'h000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
